// File: rtl/ripe_blkseq.sv
// ---------------------------------------------------------------------------
// ripe_blkseq -- multi-block sequencer for the RIPEMD-160 hash core.
//
// A job is a run of blkcnt consecutive 512-bit message blocks in hash RAM.
// For each block the sequencer:
//   1. pulses core_start for one cycle,
//   2. waits out the core's fixed round schedule (RUNCYC cycles),
//   3. raises comb_req and holds it until the chaining-value combine stage
//      answers with comb_ack.
// After the last block it emits a one-cycle done pulse. A request with
// blkcnt == 0 is rejected: done and err pulse together and the sequencer
// never leaves IDLE.
//
// The sequencer owns the message base pointer. msgbase starts at MSG_BASE
// and advances by BLKWORDS per block, wrapping modulo 2^AW.
//
// Parameters
//   AW        hash RAM address width
//   MSG_BASE  RAM word address of the first message block
//   BLKWORDS  64-bit RAM words per 512-bit block (base pointer step)
//   RUNCYC    core busy cycles per block, counted from the cycle after
//             core_start (must be >= 1)
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   req         in   job request pulse, sampled only in IDLE
//   blkcnt      in   [7:0] number of blocks, sampled with req
//   abort       in   cancel the job in progress (ignored in IDLE)
//   busy        out  high in every state except IDLE
//   done        out  one-cycle pulse at job end
//   err         out  qualifies done: job rejected because blkcnt was 0
//   core_start  out  one-cycle start pulse to the hash core
//   msgbase     out  [AW-1:0] RAM base address of the current block
//   blkidx      out  [7:0] 0-based index of the current block
//   comb_req    out  request to the chaining-value combine stage
//   comb_ack    in   combine complete, sampled only while comb_req is high
//
// Every output is either a flop or a decode of the state register, so there
// is no combinational path from any input to any output.
// ---------------------------------------------------------------------------
module ripe_blkseq #(
  parameter int unsigned AW       = 10,
  parameter int unsigned MSG_BASE = 32,
  parameter int unsigned BLKWORDS = 8,
  parameter int unsigned RUNCYC   = 453
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic [7:0]    blkcnt,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          core_start,
  output logic [AW-1:0] msgbase,
  output logic [7:0]    blkidx,
  output logic          comb_req,
  input  logic          comb_ack
);

  // Round-schedule counter only ever holds RUNCYC-1 down to 0, so
  // ceil(log2(RUNCYC)) bits suffice; RUNCYC == 1 still needs one bit.
  localparam int unsigned CW = (RUNCYC > 1) ? $clog2(RUNCYC) : 1;

  localparam logic [CW-1:0] CNT_LOAD  = CW'(RUNCYC - 1);
  localparam logic [AW-1:0] BASE_INIT = AW'(MSG_BASE);
  localparam logic [AW-1:0] BASE_STEP = AW'(BLKWORDS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_RUN,
    ST_COMB,
    ST_DONE
  } state_e;

  state_e          state_q,   state_d;
  logic [CW-1:0]   cnt_q,     cnt_d;
  logic [7:0]      blkcnt_q,  blkcnt_d;
  logic [7:0]      blkidx_q,  blkidx_d;
  logic [AW-1:0]   msgbase_q, msgbase_d;
  logic            done_q,    done_d;
  logic            err_q,     err_d;

  logic            last_blk;

  // Current block is the final one of the job.
  assign last_blk = (blkidx_q == (blkcnt_q - 8'd1));

  // -------------------------------------------------------------------------
  // Next-state and datapath update
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case statement; a path
    // that leaves one unassigned would infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    blkcnt_d  = blkcnt_q;
    blkidx_d  = blkidx_q;
    msgbase_d = msgbase_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (blkcnt != 8'd0) begin
            blkcnt_d  = blkcnt;
            blkidx_d  = 8'd0;
            msgbase_d = BASE_INIT;
            state_d   = ST_START;
          end else begin
            // Rejected job: the pulse comes out of IDLE on the next cycle,
            // busy never rises and blkidx/msgbase are left untouched.
            done_d = 1'b1;
            err_d  = 1'b1;
          end
        end
      end

      ST_START: begin
        cnt_d   = CNT_LOAD;
        state_d = ST_RUN;
      end

      ST_RUN: begin
        if (cnt_q == '0) begin
          state_d = ST_COMB;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_COMB: begin
        if (comb_ack) begin
          if (last_blk) begin
            // done is registered so it is high exactly while in DONE.
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            blkidx_d  = blkidx_q + 8'd1;
            msgbase_d = msgbase_q + BASE_STEP;  // wraps modulo 2^AW
            state_d   = ST_START;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort wins over a simultaneous comb_ack or counter expiry: the block
    // pointer does not advance and no done pulse is produced.
    if (abort && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      blkidx_d  = blkidx_q;
      msgbase_d = msgbase_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      blkcnt_q  <= 8'd0;
      blkidx_q  <= 8'd0;
      msgbase_q <= BASE_INIT;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      blkcnt_q  <= blkcnt_d;
      blkidx_q  <= blkidx_d;
      msgbase_q <= msgbase_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: flops or pure state decodes
  // -------------------------------------------------------------------------
  assign busy       = (state_q != ST_IDLE);
  assign core_start = (state_q == ST_START);
  assign comb_req   = (state_q == ST_COMB);
  assign done       = done_q;
  assign err        = err_q;
  assign msgbase    = msgbase_q;
  assign blkidx     = blkidx_q;

endmodule

// File: tb/tb_ripe_blkseq.sv
// ---------------------------------------------------------------------------
// tb_ripe_blkseq -- self-checking bench for ripe_blkseq.
//
// Two instances share clk and reset:
//   dut_a  short schedule (RUNCYC=4) with MSG_BASE=1016 so the base pointer
//          wraps on the second block; used for directed and random jobs.
//   dut_b  default parameters; used for the full-length schedule timing.
//
// For each job the reference model lays out the expected timeline as plain
// arithmetic: block i starts at s_i, runs RUNCYC cycles, then waits in the
// combine handshake for 1 + ack_delay[i] cycles; s_{i+1} follows directly.
// An abort truncates the timeline. Outputs are compared on the falling edge.
// ---------------------------------------------------------------------------
module tb_ripe_blkseq;

  localparam int AW_A       = 10;
  localparam int MSG_BASE_A = 1016;
  localparam int BLKWORDS_A = 8;
  localparam int RUNCYC_A   = 4;

  localparam int AW_B       = 10;
  localparam int RUNCYC_B   = 453;

  localparam int MAXL       = 128;

  logic            clk;
  logic            reset;

  logic            req, abort, comb_ack;
  logic [7:0]      blkcnt;
  logic            busy, done, err, core_start, comb_req;
  logic [AW_A-1:0] msgbase;
  logic [7:0]      blkidx;

  logic            req_b, abort_b, comb_ack_b;
  logic [7:0]      blkcnt_b;
  logic            busy_b, done_b, err_b, core_start_b, comb_req_b;
  logic [AW_B-1:0] msgbase_b;
  logic [7:0]      blkidx_b;

  int n_checks;
  int n_errors;
  int job_no;

  // Per-job expected timeline, indexed by cycle relative to the req cycle.
  // A value of -1 means "not compared in this cycle".
  int e_busy  [MAXL];
  int e_start [MAXL];
  int e_comb  [MAXL];
  int e_done  [MAXL];
  int e_err   [MAXL];
  int e_idx   [MAXL];
  int e_base  [MAXL];
  int e_ack   [MAXL];
  int ack_delay [256];

  ripe_blkseq #(
    .AW(AW_A), .MSG_BASE(MSG_BASE_A), .BLKWORDS(BLKWORDS_A), .RUNCYC(RUNCYC_A)
  ) dut_a (
    .clk(clk), .reset(reset), .req(req), .blkcnt(blkcnt), .abort(abort),
    .busy(busy), .done(done), .err(err), .core_start(core_start),
    .msgbase(msgbase), .blkidx(blkidx), .comb_req(comb_req),
    .comb_ack(comb_ack)
  );

  ripe_blkseq dut_b (
    .clk(clk), .reset(reset), .req(req_b), .blkcnt(blkcnt_b), .abort(abort_b),
    .busy(busy_b), .done(done_b), .err(err_b), .core_start(core_start_b),
    .msgbase(msgbase_b), .blkidx(blkidx_b), .comb_req(comb_req_b),
    .comb_ack(comb_ack_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int cyc,
                       input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_errors++;
        $error("FAIL %s job%0d cyc%0d: got %0h expected %0h",
               tag, job_no, cyc, obs, exp);
      end
  endtask

  function automatic int exp_base(input int i);
    return (MSG_BASE_A + i * BLKWORDS_A) % (1 << AW_A);
  endfunction

  // Compare every dut_a output against the timeline entry for cycle k.
  task automatic check_cycle(input int k);
    if (e_busy[k] >= 0) check("busy", k, {31'd0, busy}, e_busy[k]);
    check("core_start", k, {31'd0, core_start}, e_start[k]);
    check("comb_req",   k, {31'd0, comb_req},   e_comb[k]);
    check("done",       k, {31'd0, done},       e_done[k]);
    check("err",        k, {31'd0, err},        e_err[k]);
    if (e_idx[k] >= 0) begin
      check("blkidx",  k, {24'd0, blkidx},  e_idx[k]);
      check("msgbase", k, {22'd0, msgbase}, e_base[k]);
    end
  endtask

  // Run one job of n blocks on dut_a using ack_delay[]. abort_sel: -1 no
  // abort, -2 abort at a random in-job cycle, >= 0 abort at that cycle.
  task automatic run_job(input int n, input int abort_sel);
    int s, blk_end, d_end, abort_at;
    job_no++;
    abort_at = abort_sel;
    for (int k = 0; k < MAXL; k++) begin
      e_busy[k] = 0; e_start[k] = 0; e_comb[k] = 0; e_done[k] = 0;
      e_err[k]  = 0; e_idx[k]  = -1; e_base[k] = -1; e_ack[k]  = 0;
    end
    if (n == 0) begin
      e_done[1] = 1;
      e_err[1]  = 1;
      d_end     = 1;
    end else begin
      s = 1;
      for (int i = 0; i < n; i++) begin
        blk_end    = s + RUNCYC_A + 1 + ack_delay[i];
        e_start[s] = 1;
        for (int k = s; k <= blk_end; k++) begin
          e_busy[k] = 1;
          e_idx[k]  = i;
          e_base[k] = exp_base(i);
          if (k > s + RUNCYC_A) e_comb[k] = 1;
        end
        e_ack[blk_end] = 1;
        s = blk_end + 1;
      end
      d_end         = s;
      e_done[s]     = 1;
      e_busy[s]     = -1;
      e_idx[s]      = n - 1;
      e_base[s]     = exp_base(n - 1);
    end

    if (abort_at == -2) begin
      if (n > 0) abort_at = int'($urandom_range(1, d_end - 1));
      else       abort_at = -1;
    end
    if (abort_at >= 0) begin
      for (int k = abort_at + 1; k < MAXL; k++) begin
        e_busy[k] = 0; e_start[k] = 0; e_comb[k] = 0; e_done[k] = 0;
        e_err[k]  = 0; e_idx[k]  = -1; e_base[k] = -1; e_ack[k]  = 0;
      end
      d_end = abort_at;
    end

    for (int k = 0; k <= d_end + 1; k++) begin
      @(negedge clk);
      check_cycle(k);
      // NOTE: stimulus is driven with blocking assignments half a cycle
      // before the sampling edge, so there is no race with the DUT.
      if (k == 0)          req = 1'b1;
      else if (k < d_end)  req = ($urandom_range(0, 3) == 0);
      else                 req = 1'b0;
      if (k == 0) blkcnt = 8'(n);
      else        blkcnt = 8'($urandom_range(0, 255));
      if (k == abort_at)             abort = 1'b1;
      else if (k == 0 || k > d_end)  abort = 1'($urandom_range(0, 1));
      else                           abort = 1'b0;
      if (e_ack[k] != 0)       comb_ack = 1'b1;
      else if (e_comb[k] != 0) comb_ack = 1'b0;
      else                     comb_ack = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    int seen, waits, got, n, mode;
    n_checks = 0;
    n_errors = 0;
    job_no   = 0;
    reset = 1'b1;
    req = 1'b0; blkcnt = 8'd0; abort = 1'b0; comb_ack = 1'b0;
    req_b = 1'b0; blkcnt_b = 8'd0; abort_b = 1'b0; comb_ack_b = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_busy",       0, {31'd0, busy},       0);
    check("rst_done",       0, {31'd0, done},       0);
    check("rst_err",        0, {31'd0, err},        0);
    check("rst_core_start", 0, {31'd0, core_start}, 0);
    check("rst_comb_req",   0, {31'd0, comb_req},   0);
    check("rst_blkidx",     0, {24'd0, blkidx},     0);
    check("rst_msgbase",    0, {22'd0, msgbase},    MSG_BASE_A);
    reset = 1'b0;

    // Single block, immediate ack.
    ack_delay[0] = 0;
    run_job(1, -1);

    // Three blocks, immediate ack; second block wraps msgbase to 0.
    for (int i = 0; i < 3; i++) ack_delay[i] = 0;
    run_job(3, -1);

    // Backpressure: ack held off 3 cycles on block 0.
    ack_delay[0] = 3; ack_delay[1] = 0;
    run_job(2, -1);

    // Rejected request.
    run_job(0, -1);

    // Abort during RUN of block 1 of 3 (block 1 starts at cycle 7).
    for (int i = 0; i < 3; i++) ack_delay[i] = 0;
    run_job(3, 9);

    // Reset pulsed during COMB of block 1; it overrides req and abort.
    job_no++;
    @(negedge clk);
    req = 1'b1; blkcnt = 8'd3; comb_ack = 1'b1; abort = 1'b0;
    @(negedge clk);
    req = 1'b0;
    seen = 0; waits = 0;
    while (seen < 2 && waits < 40) begin
      @(negedge clk);
      waits++;
      if (comb_req === 1'b1) seen++;
    end
    check("reach_comb", waits, seen, 2);
    check("pre_rst_blkidx", waits, {24'd0, blkidx}, 1);
    reset = 1'b1; req = 1'b1; blkcnt = 8'd1; abort = 1'b1; comb_ack = 1'b0;
    @(negedge clk);
    check("mid_rst_busy",       0, {31'd0, busy},       0);
    check("mid_rst_done",       0, {31'd0, done},       0);
    check("mid_rst_err",        0, {31'd0, err},        0);
    check("mid_rst_core_start", 0, {31'd0, core_start}, 0);
    check("mid_rst_comb_req",   0, {31'd0, comb_req},   0);
    check("mid_rst_blkidx",     0, {24'd0, blkidx},     0);
    check("mid_rst_msgbase",    0, {22'd0, msgbase},    MSG_BASE_A);
    reset = 1'b0; req = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("post_rst_busy", 1, {31'd0, busy}, 0);
    check("post_rst_done", 1, {31'd0, done}, 0);

    // Random jobs: block counts, ack delays, aborts and stray inputs.
    for (int j = 0; j < 40; j++) begin
      n = int'($urandom_range(0, 5));
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 1) == 0) ack_delay[i] = 0;
        else                           ack_delay[i] = int'($urandom_range(1, 3));
      end
      if ($urandom_range(0, 4) == 0) mode = -2;
      else                           mode = -1;
      run_job(n, mode);
    end

    // Default schedule on dut_b: one block, ack tied high.
    job_no++;
    @(negedge clk);
    req_b = 1'b1; blkcnt_b = 8'd1;
    got = -1;
    for (int k = 1; k <= 600 && got < 0; k++) begin
      @(negedge clk);
      req_b = 1'b0;
      if (done_b === 1'b1) got = k;
    end
    check("b_done_cycle", got, got, 1 * (RUNCYC_B + 2) + 1);
    check("b_err", got, {31'd0, err_b}, 0);
    check("b_msgbase", got, {22'd0, msgbase_b}, 32);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
